spi_reg_interface: RTL

Parametrised SPI slave that bridges an external master to the internal register file of the function generator. It oversamples SCK/CS/MOSI on `sys_clk_i`, decodes a command word (R/W + address), and issues single-cycle read/write strobes with optional address auto-increment bursts. It sits between the board SPI pins and the register file, replacing the fixed-width first-generation interface.

---
 rtl/spi_reg_interface.sv | 236 +++++++++++++++++++++++
 1 files changed

// File: rtl/spi_reg_interface.sv
// spi_reg_interface: SPI mode-0 slave bridging an external master to the
// internal register file. SCK/CS/MOSI are oversampled on sys_clk_i; a command
// word {rd, addr} is followed by one data word (or a burst of data words).
//
// Build option: define INT_BURST_EN to keep the frame open after each data
// word with address auto-increment (wrapping at 2^ADDR_WIDTH). Without it a
// frame carries exactly one data word and further SCK edges are ignored.
//
// Register-side handshake: int_re_o / int_we_o are single-cycle qualifiers
// with no backpressure. int_addr_o is valid in the strobe cycle, int_data_o
// in the int_we_o cycle, and the register file must present int_data_i
// exactly RD_LATENCY cycles after the int_re_o cycle. Both strobes are never
// high together, and each data word produces at most one strobe.
//
// dbg_state_o exposes the FSM state: 0 IDLE, 1 CMD, 2 DATA, 3 WAIT_CS.
module spi_reg_interface #(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 16,
  parameter int RD_LATENCY = 1
) (
  input  logic                  sys_clk_i,
  input  logic                  sys_rst_i,
  input  logic                  int_clk_i,
  input  logic                  int_cs_i,
  input  logic                  int_mosi_i,
  output logic                  int_miso_o,
  output logic                  int_re_o,
  output logic                  int_we_o,
  output logic [ADDR_WIDTH-1:0] int_addr_o,
  output logic [DATA_WIDTH-1:0] int_data_o,
  input  logic [DATA_WIDTH-1:0] int_data_i,
  output logic                  int_frame_err_o,
  output logic [1:0]            dbg_state_o
);

  localparam int CMD_BITS = 1 + ADDR_WIDTH;
  localparam int MAX_BITS = (CMD_BITS > DATA_WIDTH) ? CMD_BITS : DATA_WIDTH;
  localparam int CNT_W    = $clog2(MAX_BITS + 1);
  localparam logic [CNT_W-1:0] CMD_LAST  = CNT_W'(CMD_BITS - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CMD     = 2'd1,
    ST_DATA    = 2'd2,
    ST_WAIT_CS = 2'd3
  } state_e;

  // Pin synchronisers and edge registers. These run freely through reset so
  // the CS level is known when reset releases.
  logic sck_meta_q, sck_sync_q, sck_prev_q;
  logic cs_meta_q, cs_sync_q, cs_prev_q;
  logic mosi_meta_q, mosi_sync_q;
  logic sck_rise, sck_fall, cs_fall, cs_rise;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        bit_cnt_q, bit_cnt_d;
  logic [ADDR_WIDTH-1:0]   cmd_sr_q, cmd_sr_d;
  logic [DATA_WIDTH-1:0]   data_rx_q, data_rx_d;
  logic [DATA_WIDTH-1:0]   tx_q, tx_d;
  logic                    is_read_q, is_read_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic                    miso_q, miso_d;
  logic                    re_q, re_d;
  logic                    we_q, we_d;
  logic                    err_q, err_d;
  logic [RD_LATENCY-1:0]   rd_pipe_q, rd_pipe_d;
  logic [CMD_BITS-1:0]     cmd_word;

  // Two-flop synchronisers plus one edge-history flop per pin; MOSI gets the
  // same two-stage delay so it lines up with the sck_rise pulse.
  always_ff @(posedge sys_clk_i) begin
    sck_meta_q  <= int_clk_i;
    sck_sync_q  <= sck_meta_q;
    sck_prev_q  <= sck_sync_q;
    cs_meta_q   <= int_cs_i;
    cs_sync_q   <= cs_meta_q;
    cs_prev_q   <= cs_sync_q;
    mosi_meta_q <= int_mosi_i;
    mosi_sync_q <= mosi_meta_q;
  end

  assign sck_rise = sck_sync_q & ~sck_prev_q;
  assign sck_fall = ~sck_sync_q & sck_prev_q;
  assign cs_fall  = ~cs_sync_q & cs_prev_q;
  assign cs_rise  = cs_sync_q & ~cs_prev_q;

  // Full command word including the bit arriving on this sck_rise.
  assign cmd_word = {cmd_sr_q, mosi_sync_q};

  // Next-state and datapath: frame decode, shifting, strobes and MISO.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    cmd_sr_d  = cmd_sr_q;
    data_rx_d = data_rx_q;
    tx_d      = tx_q;
    is_read_d = is_read_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    miso_d    = miso_q;
    re_d      = 1'b0;
    we_d      = 1'b0;
    err_d     = 1'b0;
    rd_pipe_d = (rd_pipe_q << 1) | RD_LATENCY'(re_q);

    // Read data lands in the transmit register RD_LATENCY cycles after re.
    if (rd_pipe_q[RD_LATENCY-1]) begin
      tx_d = int_data_i;
    end

`ifdef INT_BURST_EN
    // Advance the address once the write strobe for this word has been seen.
    if (we_q) begin
      addr_d = addr_q + ADDR_WIDTH'(1);
    end
`endif

    if (cs_rise) begin
      // End of frame from any state; a partial word is dropped and flagged.
      state_d   = ST_IDLE;
      miso_d    = 1'b0;
      rd_pipe_d = '0;
      if ((state_q == ST_CMD || state_q == ST_DATA) && bit_cnt_q != '0) begin
        err_d = 1'b1;
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          miso_d = 1'b0;
          if (cs_fall) begin
            state_d   = ST_CMD;
            bit_cnt_d = '0;
            cmd_sr_d  = '0;
            data_rx_d = '0;
            tx_d      = '0;
          end
        end
        ST_CMD: begin
          miso_d = 1'b0;
          if (sck_rise) begin
            if (bit_cnt_q == CMD_LAST) begin
              bit_cnt_d = '0;
              is_read_d = cmd_word[CMD_BITS-1];
              addr_d    = cmd_word[ADDR_WIDTH-1:0];
              re_d      = cmd_word[CMD_BITS-1];
              state_d   = ST_DATA;
            end else begin
              cmd_sr_d  = cmd_word[ADDR_WIDTH-1:0];
              bit_cnt_d = bit_cnt_q + CNT_W'(1);
            end
          end
        end
        ST_DATA: begin
          if (!is_read_q) begin
            miso_d = 1'b0;
          end else if (sck_fall) begin
            miso_d = tx_q[DATA_WIDTH-1];
            tx_d   = tx_q << 1;
          end
          if (sck_rise) begin
            data_rx_d = {data_rx_q[DATA_WIDTH-2:0], mosi_sync_q};
            if (bit_cnt_q == DATA_LAST) begin
              bit_cnt_d = '0;
              if (!is_read_q) begin
                wdata_d = {data_rx_q[DATA_WIDTH-2:0], mosi_sync_q};
                we_d    = 1'b1;
              end
`ifdef INT_BURST_EN
              if (is_read_q) begin
                addr_d = addr_q + ADDR_WIDTH'(1);
                re_d   = 1'b1;
              end
`else
              state_d = ST_WAIT_CS;
              miso_d  = 1'b0;
`endif
            end else begin
              bit_cnt_d = bit_cnt_q + CNT_W'(1);
            end
          end
        end
        ST_WAIT_CS: begin
          miso_d = 1'b0;
        end
        default: begin
          state_d = ST_IDLE;
          miso_d  = 1'b0;
        end
      endcase
    end
  end

  // State register; reset lands in WAIT_CS when a frame is already open.
  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      state_q   <= cs_sync_q ? ST_IDLE : ST_WAIT_CS;
      bit_cnt_q <= '0;
      cmd_sr_q  <= '0;
      data_rx_q <= '0;
      tx_q      <= '0;
      is_read_q <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      miso_q    <= 1'b0;
      re_q      <= 1'b0;
      we_q      <= 1'b0;
      err_q     <= 1'b0;
      rd_pipe_q <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      cmd_sr_q  <= cmd_sr_d;
      data_rx_q <= data_rx_d;
      tx_q      <= tx_d;
      is_read_q <= is_read_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      miso_q    <= miso_d;
      re_q      <= re_d;
      we_q      <= we_d;
      err_q     <= err_d;
      rd_pipe_q <= rd_pipe_d;
    end
  end

  assign int_miso_o      = miso_q;
  assign int_re_o        = re_q;
  assign int_we_o        = we_q;
  assign int_addr_o      = addr_q;
  assign int_data_o      = wdata_q;
  assign int_frame_err_o = err_q;
  assign dbg_state_o     = state_q;

endmodule
